uart_tx_fifo: RTL and testbench

- Byte FIFO between the CPU's memory-mapped UART data register and uart_tx.
- CPU store to the UART address pushes one byte. The block pops bytes and drives uart_tx's data/start/ready handshake.
- The processor clock no longer needs to be gated while a character is in flight.
- Single clock domain: the block and uart_tx share clk.

---
 rtl/uart_tx_fifo.sv | 143 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between the CPU UART data register and uart_tx.
// A CPU store to TX_ADDR pushes bus_wdata[7:0]. The FSM pops one byte at a time
// and runs the uart_tx start/ready handshake.
// Optional build macro UART_TX_FIFO_OVF_EN adds a sticky overflow flag (ovf),
// a saturating dropped-byte counter (ovf_cnt) and their clear input (ovf_clr).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a byte and an idle uart_tx; pops on exit
// START     | tx_start high for this single cycle
// WAIT_BUSY | waiting for uart_tx to go busy; restarts after 2 idle cycles
// WAIT_DONE | uart_tx busy; waiting for it to return idle
module uart_tx_fifo #(
  parameter int          DEPTH   = 16,
  parameter int          AW      = 4,
  parameter logic [31:0] TX_ADDR = 32'h2001
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [31:0]   bus_addr,
  input  logic [31:0]   bus_wdata,
  input  logic          bus_memwrite,
  output logic          stall,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_ready,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
`ifdef UART_TX_FIFO_OVF_EN
  ,
  input  logic          ovf_clr,
  output logic          ovf,
  output logic [7:0]    ovf_cnt
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state, state_nx;
  logic          busy_tmr, busy_tmr_nx;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          store_hit, push, pop;
  logic          wdata_unused;

  assign wdata_unused = ^bus_wdata[31:8];

  assign store_hit = bus_memwrite && (bus_addr == TX_ADDR);
  assign push      = store_hit && !full;
  assign stall     = store_hit && full;
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);

  // Byte storage; contents are meaningless after reset since pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus_wdata[7:0];
  end

  // Pointers and occupancy; count disambiguates full from empty on wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output byte is captured only on pop so it stays stable across restarts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tx_data <= 8'h00;
    else if (pop) tx_data <= mem[rd_ptr];
  end

  // FSM state, restart timer and registered start pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      busy_tmr <= 1'b0;
      tx_start <= 1'b0;
    end else begin
      state    <= state_nx;
      busy_tmr <= busy_tmr_nx;
      tx_start <= (state_nx == START);
    end
  end

  // Next-state and pop decode; the down-counter allows two idle-ready cycles
  // in WAIT_BUSY before the start pulse is reissued.
  always_comb begin
    state_nx    = state;
    busy_tmr_nx = busy_tmr;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && tx_ready) begin
          pop      = 1'b1;
          state_nx = START;
        end
      end
      START: begin
        state_nx    = WAIT_BUSY;
        busy_tmr_nx = 1'b1;
      end
      WAIT_BUSY: begin
        if (!tx_ready)          state_nx = WAIT_DONE;
        else if (busy_tmr == 1'b0) state_nx = START;
        else                    busy_tmr_nx = busy_tmr - 1'b1;
      end
      WAIT_DONE: begin
        if (tx_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef UART_TX_FIFO_OVF_EN
  // Sticky overflow flag; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        ovf <= 1'b0;
    else if (stall)   ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  // Saturating dropped-byte counter; clear takes priority over counting.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          ovf_cnt <= 8'h00;
    else if (ovf_clr)                   ovf_cnt <= 8'h00;
    else if (stall && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a uart_tx
// model answers the handshake, and a monitor checks every start pulse.
module tb_uart_tx_fifo;
  localparam int          DEPTH   = 16;
  localparam int          AW      = 4;
  localparam logic [31:0] TX_ADDR = 32'h2001;

  logic          clk;
  logic          rstn;
  logic [31:0]   bus_addr;
  logic [31:0]   bus_wdata;
  logic          bus_memwrite;
  logic          stall;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_ready;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
`ifdef UART_TX_FIFO_OVF_EN
  logic          ovf_clr;
  logic          ovf;
  logic [7:0]    ovf_cnt;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .TX_ADDR(TX_ADDR)) dut (
    .clk(clk), .rstn(rstn), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_memwrite(bus_memwrite), .stall(stall), .tx_data(tx_data),
    .tx_start(tx_start), .tx_ready(tx_ready), .full(full), .empty(empty),
    .count(count)
`ifdef UART_TX_FIFO_OVF_EN
    , .ovf_clr(ovf_clr), .ovf(ovf), .ovf_cnt(ovf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus-owned
  logic [7:0] exp_q[$];
  logic       exp_stall;
  logic       hold_busy, long_busy;
  int         ign_req;
  int         p_req, p_count;
  logic       p_chk_s, p_s, p_chk_d, p_to;
  logic [7:0] p_d;
  string      p_name;
`ifdef UART_TX_FIFO_OVF_EN
  int         o_req;
  logic       o_ovf;
  logic [7:0] o_cnt;
  string      o_name;
  int         o_seen;
`endif
  // uart model-owned
  int         busy_left, ign_done;
  logic       start_ignored;
  // monitor-owned
  int         checks, failures, rd_idx, mcyc, last_ign, p_seen;
  bit         ign_pending;

  // uart_tx model: goes busy the cycle after an accepted start, or ignores a
  // start on request so the restart path is exercised.
  always @(posedge clk) begin
    #2;
    start_ignored = 1'b0;
    if (!rstn) busy_left = 0;
    else begin
      if (busy_left > 0) busy_left--;
      if (tx_start) begin
        if (ign_req != ign_done) begin
          ign_done++;
          start_ignored = 1'b1;
        end else busy_left = long_busy ? 40 : int'($urandom_range(2, 5));
      end
    end
    tx_ready = !hold_busy && (busy_left == 0);
  end

  function automatic void chk(input bit ok, input string nm,
                              input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  // Monitor: scoreboard on start pulses, stall checks, and probe requests.
  always @(negedge clk) begin
    mcyc++;
    if (!rstn) begin
      rd_idx      = exp_q.size();
      ign_pending = 1'b0;
    end else if (tx_start) begin
      if (ign_pending) begin
        chk(mcyc - last_ign == 3, "restart_gap", mcyc - last_ign, 3);
        ign_pending = 1'b0;
      end
      if (rd_idx >= exp_q.size()) chk(1'b0, "unexpected_start", tx_data, 0);
      else begin
        chk(tx_data == exp_q[rd_idx], "tx_data", tx_data, exp_q[rd_idx]);
        if (start_ignored) begin
          ign_pending = 1'b1;
          last_ign    = mcyc;
        end else rd_idx++;
      end
    end
    if (bus_memwrite) begin
      if (bus_addr == TX_ADDR) chk(stall == exp_stall, "stall", stall, exp_stall);
      else chk(stall == 1'b0, "stall_miss", stall, 0);
    end
    if (p_req != p_seen) begin
      p_seen = p_req;
      if (p_to) chk(1'b0, {p_name, "_timeout"}, 0, 1);
      else begin
        chk(int'(count) == p_count, {p_name, "_count"}, count, p_count);
        chk(full == (p_count == DEPTH), {p_name, "_full"}, full, p_count == DEPTH);
        chk(empty == (p_count == 0), {p_name, "_empty"}, empty, p_count == 0);
        if (p_chk_s) chk(tx_start == p_s, {p_name, "_start"}, tx_start, p_s);
        if (p_chk_d) chk(tx_data == p_d, {p_name, "_data"}, tx_data, p_d);
      end
    end
`ifdef UART_TX_FIFO_OVF_EN
    if (o_req != o_seen) begin
      o_seen = o_req;
      chk(ovf == o_ovf, {o_name, "_ovf"}, ovf, o_ovf);
      chk(ovf_cnt == o_cnt, {o_name, "_ovf_cnt"}, ovf_cnt, o_cnt);
    end
`endif
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic stl);
    bus_addr = a; bus_wdata = d; bus_memwrite = 1'b1; exp_stall = stl;
    if (a == TX_ADDR && !stl) exp_q.push_back(d[7:0]);
    cyc();
    bus_memwrite = 1'b0; exp_stall = 1'b0;
  endtask

  task automatic probe(input int cnt, input logic chk_s, input logic s,
                       input logic chk_d, input logic [7:0] d, input logic to,
                       input string nm);
    p_count = cnt; p_chk_s = chk_s; p_s = s; p_chk_d = chk_d; p_d = d;
    p_to = to; p_name = nm;
    p_req++;
    @(negedge clk); #1;
    cyc();
  endtask

`ifdef UART_TX_FIFO_OVF_EN
  task automatic probe_ovf(input logic ov, input logic [7:0] c, input string nm);
    o_ovf = ov; o_cnt = c; o_name = nm;
    o_req++;
    @(negedge clk); #1;
    cyc();
  endtask
`endif

  task automatic drain(input int budget, input string nm);
    int n = 0;
    while ((rd_idx != exp_q.size() || busy_left != 0 || !tx_ready) && n < budget) begin
      cyc();
      n++;
    end
    if (n >= budget) probe(0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pushed, iter, r;
    logic [31:0] a;
    rstn = 1'b0; bus_addr = '0; bus_wdata = '0; bus_memwrite = 1'b0;
    exp_stall = 1'b0; hold_busy = 1'b0; long_busy = 1'b0; ign_req = 0;
    p_req = 0; p_count = 0; p_chk_s = 0; p_s = 0; p_chk_d = 0; p_d = 0; p_to = 0;
`ifdef UART_TX_FIFO_OVF_EN
    ovf_clr = 1'b0; o_req = 0; o_ovf = 0; o_cnt = 0;
`endif
    repeat (3) cyc();
    rstn = 1'b1;
    cyc();
    probe(0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, "reset");
`ifdef UART_TX_FIFO_OVF_EN
    probe_ovf(1'b0, 8'h00, "reset");
`endif

    // single byte: start pulse two cycles after the store
    store(TX_ADDR, 32'h41, 1'b0);
    probe(1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "lat1");
    probe(0, 1'b1, 1'b1, 1'b1, 8'h41, 1'b0, "lat2");
    drain(100, "single_drain");
    probe(0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "single_empty");

    // store to a neighbouring address is ignored
    store(32'h2000, 32'h55, 1'b0);
    repeat (3) cyc();
    probe(0, 1'b1, 1'b0, 1'b1, 8'h41, 1'b0, "miss");

    // uart ignores one start: same byte restarts three cycles later
    ign_req++;
    store(TX_ADDR, 32'h3C, 1'b0);
    drain(100, "restart_drain");

    // fill to full with uart busy, then one dropped store
    hold_busy = 1'b1;
    cyc();
    for (int i = 0; i < DEPTH; i++) store(TX_ADDR, i, 1'b0);
    probe(DEPTH, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "fill");
    store(TX_ADDR, 32'hAA, 1'b1);
    probe(DEPTH, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "drop");
`ifdef UART_TX_FIFO_OVF_EN
    probe_ovf(1'b1, 8'h01, "ovf1");
    store(TX_ADDR, 32'hAB, 1'b1);
    store(TX_ADDR, 32'hAC, 1'b1);
    probe_ovf(1'b1, 8'h03, "ovf3");
    ovf_clr = 1'b1;
    store(TX_ADDR, 32'hAD, 1'b1);
    ovf_clr = 1'b0;
    probe_ovf(1'b1, 8'h00, "ovf_clr_drop");
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    probe_ovf(1'b0, 8'h00, "ovf_clr");
`endif
    hold_busy = 1'b0;
    drain(400, "full_drain");
    probe(0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "full_empty");

    // push and pop in the same cycle at count 5, then randomized streaming
    hold_busy = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) store(TX_ADDR, 32'h60 + i, 1'b0);
    probe(5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "five");
    hold_busy = 1'b0;
    store(TX_ADDR, 32'h65, 1'b0);
    probe(5, 1'b1, 1'b1, 1'b1, 8'h60, 1'b0, "push_pop");
    pushed = 6;
    iter = 0;
    while (pushed < 40 && iter < 3000) begin
      r = int'($urandom_range(0, 9));
      if (r < 5 && exp_q.size() - rd_idx < DEPTH) begin
        store(TX_ADDR, $urandom, 1'b0);
        pushed++;
      end else if (r == 5) begin
        a = $urandom;
        if (a == TX_ADDR) a = 32'h0;
        store(a, $urandom, 1'b0);
      end else if (r == 6 && ign_req == ign_done) begin
        ign_req++;
        cyc();
      end else cyc();
      iter++;
    end
    if (pushed < 40) probe(0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "stream");
    drain(2000, "stream_drain");
    probe(0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "stream_empty");

    // async reset while in WAIT_DONE with three bytes queued
    long_busy = 1'b1;
    for (int i = 0; i < 4; i++) store(TX_ADDR, 32'h90 + i, 1'b0);
    repeat (3) cyc();
    probe(3, 1'b1, 1'b0, 1'b1, 8'h90, 1'b0, "pre_reset");
    rstn = 1'b0;
    #1;
    probe(0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, "mid_reset");
    rstn = 1'b1;
    long_busy = 1'b0;
    repeat (30) cyc();
    probe(0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, "post_reset");

    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
